adc_control: RTL and testbench

- Readback counterpart of the DAC serial loader.
- Drives a 16-bit SPI-style ADC with nCnv, sclk and sdo pins.
- Shifts each conversion result in MSB-first and holds it in a sample register.
- The EBI host reads the sample and status through the same re/wr/data/addr bus used by the other peripheral blocks.

---
 rtl/adc_pkg.sv | 37 +++
 rtl/adc_sclk_gen.sv | 51 +++++
 rtl/adc_control.sv | 199 +++++++++++++++++++
 tb/tb_adc_control.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC readback block: FSM states, control/status
// bit positions and the sample width.
package adc_pkg;

    localparam int unsigned SAMPLE_W = 16;

    // Control register (POSITION+1 write) bit positions
    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_CONT    = 1;
    localparam int unsigned CTRL_CLR_OVR = 2;

    // Status register (POSITION+1 read) bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_NEW  = 1;
    localparam int unsigned STAT_OVR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_t;

    function automatic logic [SAMPLE_W-1:0] status_word(
        input logic i_ovr,
        input logic i_new_flag,
        input logic i_busy
    );
        logic [SAMPLE_W-1:0] w_word;
        w_word             = '0;
        w_word[STAT_OVR]   = i_ovr;
        w_word[STAT_NEW]   = i_new_flag;
        w_word[STAT_BUSY]  = i_busy;
        return w_word;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Divide-by-CLK_DIV serial clock generator: idles low while disabled, emits
// rise/fall strobes one cycle ahead of the edge and counts falling edges.
module adc_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic       o_sclk,
    output logic       o_rise,
    output logic       o_fall,
    output logic [4:0] o_edge_cnt
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic [4:0]       r_edge_cnt;
    logic             w_tick;

    assign w_tick = i_en && (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_sclk     <= 1'b0;
            r_edge_cnt <= '0;
        end else if (!i_en) begin
            r_div      <= '0;
            r_sclk     <= 1'b0;
            r_edge_cnt <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
                r_edge_cnt <= r_edge_cnt + 5'd1;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Strobes are true on the cycle whose closing edge moves the pin
    assign o_rise     = w_tick & ~r_sclk;
    assign o_fall     = w_tick & r_sclk;
    assign o_sclk     = r_sclk;
    assign o_edge_cnt = r_edge_cnt;

endmodule

// File: rtl/adc_control.sv
// EBI-mapped controller for a 16-bit serial ADC: runs the convert/shift
// sequence, holds the last result and exposes sample and status registers.
module adc_control
    import adc_pkg::*;
#(
    parameter int unsigned POSITION    = 0,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 64
) (
    input  logic        ebi_clk,
    input  logic        nReset,
    input  logic        re,
    input  logic        wr,
    input  logic [15:0] data,
    input  logic [20:0] addr,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        nCnv,
    output logic        adc_sclk,
    input  logic        adc_sdo
);

    localparam logic [7:0] ADDR_SAMPLE = 8'(POSITION);
    localparam logic [7:0] ADDR_CTRL   = 8'(POSITION + 1);
    localparam int unsigned CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);

    // Bus front end
    logic        r_cs_s;
    logic        r_cs_c;
    logic        r_re;
    logic        r_wr;
    logic [2:0]  r_wdata;

    // Conversion engine
    adc_state_t           r_state;
    adc_state_t           w_next_state;
    logic [CONV_W-1:0]    r_conv_cnt;
    logic [SAMPLE_W-1:0]  r_shift;
    logic [SAMPLE_W-1:0]  r_sample;
    logic                 r_ncnv;
    logic                 r_busy;

    // Host-visible control/status
    logic                 r_cont;
    logic                 r_new;
    logic                 r_ovr;
    logic [SAMPLE_W-1:0]  r_data_out;

    logic        w_rd_s;
    logic        w_rd_c;
    logic        w_wr_c;
    logic        w_start;
    logic        w_clr_ovr;
    logic        w_ovr_set;
    logic        w_shift_en;
    logic        w_rise;
    logic        w_fall;
    logic        w_last_bit;
    logic [4:0]  w_edge_cnt;
    logic        w_unused;

    assign w_rd_s     = r_cs_s & r_re;
    assign w_rd_c     = r_cs_c & r_re;
    assign w_wr_c     = r_cs_c & r_wr;
    assign w_start    = w_wr_c & r_wdata[CTRL_START];
    assign w_clr_ovr  = w_wr_c & r_wdata[CTRL_CLR_OVR];
    assign w_shift_en = (r_state == ST_SHIFT);
    assign w_last_bit = w_fall && (w_edge_cnt == 5'd15);
    // A sample read landing on DONE returns the old word, so it must not
    // count as consuming the new one nor flag an overrun.
    assign w_ovr_set  = (r_state == ST_DONE) && r_new && !w_rd_s;
    assign w_unused   = ^{addr[20:8], data[15:3], w_rise};

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk      (ebi_clk),
        .i_rst_n    (nReset),
        .i_en       (w_shift_en),
        .o_sclk     (adc_sclk),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_edge_cnt (w_edge_cnt)
    );

    always_ff @(posedge ebi_clk or negedge nReset) begin
        if (!nReset) begin
            r_cs_s  <= 1'b0;
            r_cs_c  <= 1'b0;
            r_re    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_cs_s  <= (addr[7:0] == ADDR_SAMPLE);
            r_cs_c  <= (addr[7:0] == ADDR_CTRL);
            r_re    <= re;
            r_wr    <= wr;
            r_wdata <= data[2:0];
        end
    end

    always_ff @(posedge ebi_clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start || r_cont) begin
                    w_next_state = ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_conv_cnt == '0) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ebi_clk or negedge nReset) begin
        if (!nReset) begin
            r_conv_cnt <= '0;
            r_shift    <= '0;
            r_sample   <= '0;
            r_ncnv     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_next_state == ST_CONV) begin
                r_conv_cnt <= CONV_LOAD;
                r_ncnv     <= 1'b0;
                r_busy     <= 1'b1;
            end else if (r_state == ST_CONV && r_conv_cnt != '0) begin
                r_conv_cnt <= r_conv_cnt - 1'b1;
            end

            if (w_shift_en && w_fall) begin
                r_shift <= {r_shift[SAMPLE_W-2:0], adc_sdo};
            end

            if (r_state == ST_DONE) begin
                r_sample <= r_shift;
                r_ncnv   <= 1'b1;
                r_busy   <= 1'b0;
            end
        end
    end

    always_ff @(posedge ebi_clk or negedge nReset) begin
        if (!nReset) begin
            r_cont     <= 1'b0;
            r_new      <= 1'b0;
            r_ovr      <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_wr_c) begin
                r_cont <= r_wdata[CTRL_CONT];
            end

            if (r_state == ST_DONE) begin
                r_new <= 1'b1;
            end else if (w_rd_s) begin
                r_new <= 1'b0;
            end

            r_ovr <= (r_ovr & ~w_clr_ovr) | w_ovr_set;

            if (w_rd_s) begin
                r_data_out <= r_sample;
            end else if (w_rd_c) begin
                r_data_out <= status_word(r_ovr, r_new, r_busy);
            end else begin
                r_data_out <= '0;
            end
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign nCnv     = r_ncnv;

endmodule

// File: tb/tb_adc_control.sv
// Self-checking bench for adc_control: serial ADC model, bus read scoreboard
// and a pin monitor that measures nCnv/adc_sclk timing per word.
module tb_adc_control;

    localparam int unsigned P_POS  = 0;
    localparam int unsigned P_DIV  = 4;
    localparam int unsigned P_CONV = 64;
    localparam int          WORD_LEN = P_CONV + 32 * P_DIV + 1;

    localparam logic [20:0] ADDR_S    = 21'(P_POS);
    localparam logic [20:0] ADDR_C    = 21'(P_POS + 1);
    localparam logic [20:0] ADDR_IDLE = 21'h0000F0;

    logic        clk;
    logic        nReset;
    logic        re;
    logic        wr;
    logic [15:0] data;
    logic [20:0] addr;
    logic [15:0] data_out;
    logic        busy;
    logic        nCnv;
    logic        adc_sclk;
    logic        adc_sdo;

    int n_checks;
    int n_pass;

    logic [15:0] exp_q[$];
    logic [15:0] adc_q[$];
    logic [15:0] adc_word;
    int          adc_bit;

    int words_done;
    int word_len;
    int word_pulses;
    int first_rise;
    int hi_min, hi_max, lo_min, lo_max;
    int cur_low, pulses, run;
    bit in_word;
    logic prev_sclk;

    adc_control #(
        .POSITION    (P_POS),
        .CLK_DIV     (P_DIV),
        .CONV_CYCLES (P_CONV)
    ) dut (
        .ebi_clk  (clk),
        .nReset   (nReset),
        .re       (re),
        .wr       (wr),
        .data     (data),
        .addr     (addr),
        .data_out (data_out),
        .busy     (busy),
        .nCnv     (nCnv),
        .adc_sclk (adc_sclk),
        .adc_sdo  (adc_sdo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: MSB ready at nCnv fall, next bit after each sclk fall
    initial begin
        adc_sdo  = 1'b0;
        adc_word = '0;
        adc_bit  = 15;
        forever begin
            @(negedge nCnv);
            adc_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
            adc_bit  = 15;
            adc_sdo  = adc_word[15];
        end
    end

    initial begin
        forever begin
            @(negedge adc_sclk);
            if (adc_bit > 0) adc_bit--;
            adc_sdo = adc_word[adc_bit];
        end
    end

    // Pin monitor, one sample per ebi_clk cycle
    initial begin
        words_done = 0; word_len = 0; word_pulses = 0; first_rise = -1;
        hi_min = 0; hi_max = 0; lo_min = 0; lo_max = 0;
        cur_low = 0; pulses = 0; run = 0; in_word = 0; prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (nReset !== 1'b1) begin
                in_word = 0;
            end else if (nCnv === 1'b0) begin
                if (!in_word) begin
                    in_word = 1; cur_low = 0; pulses = 0; first_rise = -1; run = 0;
                    prev_sclk = 1'b0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
                end
                cur_low++;
                if (adc_sclk !== prev_sclk) begin
                    if (prev_sclk === 1'b1) begin
                        if (run < hi_min) hi_min = run;
                        if (run > hi_max) hi_max = run;
                    end else if (pulses > 0) begin
                        if (run < lo_min) lo_min = run;
                        if (run > lo_max) lo_max = run;
                    end
                    if (adc_sclk === 1'b1) begin
                        if (pulses == 0) first_rise = cur_low - 1;
                        pulses++;
                    end
                    run = 1;
                end else begin
                    run++;
                end
                prev_sclk = adc_sclk;
            end else if (in_word) begin
                in_word     = 0;
                word_len    = cur_low;
                word_pulses = pulses;
                words_done++;
            end
        end
    end

    task automatic ebi_write(input logic [20:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; data = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; addr = ADDR_IDLE; data = '0;
    endtask

    task automatic ebi_read(input logic [20:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        addr = a; re = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        re = 1'b0; addr = ADDR_IDLE;
        @(negedge clk);
        check(tag, data_out, exp_q.pop_front());
    endtask

    task automatic wait_words(input int target, input string tag);
        int guard = 0;
        while (words_done < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, words_done, target);
    endtask

    task automatic wait_sclk(input bit rising, input int n, input string tag);
        int   cnt   = 0;
        int   guard = 0;
        logic prev  = adc_sclk;
        while (cnt < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
            if (rising && adc_sclk === 1'b1 && prev === 1'b0) cnt++;
            if (!rising && adc_sclk === 1'b0 && prev === 1'b1) cnt++;
            prev = adc_sclk;
        end
        check(tag, cnt, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        n_checks = 0; n_pass = 0;
        nReset = 1'b0; re = 1'b0; wr = 1'b0; data = '0; addr = ADDR_IDLE;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ncnv", nCnv, 1'b1);
        check("rst_sclk", adc_sclk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dout", data_out, 16'h0000);
        nReset = 1'b1;
        ebi_read(ADDR_C, 16'h0000, "rst_status");
        ebi_read(ADDR_S, 16'h0000, "rst_sample");

        // Single conversion with pin timing
        base = words_done;
        adc_q.push_back(16'hA5C3);
        ebi_write(ADDR_C, 16'h0001);
        wait_words(base + 1, "single_word_done");
        check("word_len", word_len, WORD_LEN);
        check("sclk_pulses", word_pulses, 16);
        check("conv_to_first_rise", first_rise, P_CONV + P_DIV);
        check("sclk_hi_min", hi_min, P_DIV);
        check("sclk_hi_max", hi_max, P_DIV);
        check("sclk_lo_min", lo_min, P_DIV);
        check("sclk_lo_max", lo_max, P_DIV);
        ebi_read(21'h000005, 16'h0000, "unsel_rd_5");
        ebi_read(ADDR_IDLE, 16'h0000, "unsel_rd_f0");
        ebi_read(ADDR_C, 16'h0002, "status_new");
        ebi_read(ADDR_S, 16'hA5C3, "sample_a5c3");
        ebi_read(ADDR_C, 16'h0000, "status_after_rd");

        // Start request while busy is ignored
        base = words_done;
        adc_q.push_back(16'h3C5A);
        adc_q.push_back(16'hDEAD);
        ebi_write(ADDR_C, 16'h0001);
        wait_sclk(1'b0, 4, "busy_bit4");
        ebi_write(ADDR_C, 16'h0001);
        ebi_read(ADDR_S, 16'hA5C3, "busy_prev_sample");
        ebi_read(ADDR_C, 16'h0001, "busy_status");
        wait_words(base + 1, "busy_word_done");
        repeat (250) @(negedge clk);
        check("single_conv_only", words_done, base + 1);
        ebi_read(ADDR_C, 16'h0002, "busy_status_end");
        ebi_read(ADDR_S, 16'h3C5A, "busy_sample");
        adc_q.delete();

        // Continuous mode with overrun
        base = words_done;
        adc_q.push_back(16'h0001);
        adc_q.push_back(16'hFFFE);
        ebi_write(ADDR_C, 16'h0002);
        wait_words(base + 2, "cont_two_words");
        repeat (5) @(negedge clk);
        ebi_read(ADDR_C, 16'h0007, "cont_status_ovr");
        ebi_read(ADDR_S, 16'hFFFE, "cont_sample");
        ebi_write(ADDR_C, 16'h0006);
        ebi_read(ADDR_C, 16'h0001, "cont_ovr_cleared");
        ebi_write(ADDR_C, 16'h0000);
        wait_words(base + 3, "cont_third_word");
        repeat (250) @(negedge clk);
        check("cont_stopped", words_done, base + 3);
        ebi_read(ADDR_C, 16'h0002, "cont_stop_status");
        ebi_read(ADDR_S, 16'h0000, "cont_third_sample");
        adc_q.delete();

        // Sample read coinciding with DONE
        base = words_done;
        adc_q.push_back(16'h0F0F);
        ebi_write(ADDR_C, 16'h0001);
        wait_words(base + 1, "prev_word_done");
        ebi_read(ADDR_S, 16'h0F0F, "prev_sample");
        adc_q.push_back(16'h1234);
        ebi_write(ADDR_C, 16'h0001);
        wait_sclk(1'b1, 16, "align_rise16");
        repeat (P_DIV - 1) @(posedge clk);
        @(negedge clk);
        addr = ADDR_S; re = 1'b1;
        exp_q.push_back(16'h0F0F);
        @(negedge clk);
        re = 1'b0; addr = ADDR_IDLE;
        @(negedge clk);
        check("done_aligned_rd", data_out, exp_q.pop_front());
        wait_words(base + 2, "align_word_done");
        ebi_read(ADDR_C, 16'h0002, "align_new_kept");
        ebi_read(ADDR_S, 16'h1234, "align_sample");
        ebi_read(ADDR_C, 16'h0000, "align_new_cleared");

        // Asynchronous reset in the middle of the shift phase
        adc_q.push_back(16'h5555);
        ebi_write(ADDR_C, 16'h0001);
        wait_sclk(1'b1, 8, "mid_shift_bit7");
        #2;
        nReset = 1'b0;
        #1;
        check("arst_ncnv", nCnv, 1'b1);
        check("arst_sclk", adc_sclk, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_dout", data_out, 16'h0000);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        ebi_read(ADDR_S, 16'h0000, "arst_sample");
        ebi_read(ADDR_C, 16'h0000, "arst_status");
        adc_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
